// File: rtl/median_frame_ctrl.sv
// -----------------------------------------------------------------------------
// median_frame_ctrl
//
// Sequencing controller for the 5x5 median line-buffer datapath. Follows the
// incoming video timing, generates the line-buffer address and write enable,
// measures the frame geometry and declares lock once it is stable, marks the
// pixels whose kernel window lies fully inside the image, and selects median
// or bypass per pixel using an enable that only changes at frame start.
//
// Ports
//   clk           pixel clock
//   rst           asynchronous reset, active low
//   rx_dv         data valid; lines are delimited by this signal
//   rx_hs         horizontal sync (only used as a polarity sanity check)
//   rx_vs         vertical sync; its edge into the active level starts a frame
//   cfg_en        median enable request, sampled at frame start
//   buf_addr      line-buffer address (equals x_cnt)
//   buf_we        line-buffer write enable
//   x_cnt         pixel index in the active line
//   y_cnt         active-line index in the frame
//   win_valid     window ending at (x_cnt, y_cnt) lies fully inside the image
//   use_median    select median output (else bypass)
//   locked        frame geometry has been stable for LOCK_FRAMES frames
//   frame_width   active width of the last frame (first line of that frame)
//   frame_height  active height of the last frame
//   err_overflow  a line of the current frame exceeded 2^ADDR_W pixels
//
// All outputs are registered: they describe the inputs of the previous cycle.
// -----------------------------------------------------------------------------
module median_frame_ctrl #(
    parameter int ADDR_W        = 11,
    parameter int Y_W           = 11,
    parameter int KERNEL        = 5,
    parameter int LOCK_FRAMES   = 2,
    parameter bit SYNC_ACT_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_dv,
    input  logic              rx_hs,
    input  logic              rx_vs,
    input  logic              cfg_en,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              buf_we,
    output logic [ADDR_W-1:0] x_cnt,
    output logic [Y_W-1:0]    y_cnt,
    output logic              win_valid,
    output logic              use_median,
    output logic              locked,
    output logic [ADDR_W:0]   frame_width,
    output logic [Y_W-1:0]    frame_height,
    output logic              err_overflow
);

    localparam int                R      = KERNEL / 2;
    localparam logic [ADDR_W-1:0] X_MAX  = '1;
    localparam logic [Y_W-1:0]    Y_MAX  = '1;
    localparam logic [ADDR_W-1:0] X_WIN  = ADDR_W'(2 * R);
    localparam logic [Y_W-1:0]    Y_WIN  = Y_W'(2 * R);
    localparam logic [3:0]        LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        BLANK,
        LINE
    } state_t;

    state_t            state_q, state_d;
    logic              vs_act_q;
    logic [ADDR_W:0]   first_w_q, first_w_d;
    logic              mism_q, mism_d;
    logic              shadow_q, shadow_d;
    logic [3:0]        stable_q, stable_d;

    logic [ADDR_W-1:0] x_d;
    logic [Y_W-1:0]    y_d;
    logic              we_d, win_d, use_d, locked_d, err_d;
    logic [ADDR_W:0]   fw_d;
    logic [Y_W-1:0]    fh_d;

    logic              vs_act, hs_act, vs_edge, geom_ok;
    logic [ADDR_W:0]   line_len;

    assign vs_act   = SYNC_ACT_HIGH ? rx_vs : ~rx_vs;
    assign hs_act   = SYNC_ACT_HIGH ? rx_hs : ~rx_hs;
    assign vs_edge  = vs_act & ~vs_act_q;
    // x_cnt holds the index of the last pixel, so the line length is one more.
    // A saturated line therefore reports 2^ADDR_W.
    assign line_len = {1'b0, x_cnt} + (ADDR_W + 1)'(1);
    assign geom_ok  = (first_w_q != '0) && (y_cnt != '0) &&
                      (first_w_q == frame_width) && (y_cnt == frame_height) &&
                      !mism_q && !err_overflow;
    assign buf_addr = x_cnt;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the block leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        x_d       = x_cnt;
        y_d       = y_cnt;
        first_w_d = first_w_q;
        mism_d    = mism_q;
        shadow_d  = shadow_q;
        stable_d  = stable_q;
        err_d     = err_overflow;
        fw_d      = frame_width;
        fh_d      = frame_height;
        we_d      = 1'b0;

        if (vs_edge) begin
            // Close the running frame (unless still waiting for the first one),
            // then open the next. A pixel arriving in this very cycle already
            // belongs to the new frame.
            if (state_q != WAIT_FRAME) begin
                fw_d     = first_w_q;
                fh_d     = y_cnt;
                stable_d = geom_ok ? ((stable_q == LOCK_N) ? stable_q : stable_q + 4'd1)
                                   : 4'd0;
            end
            x_d       = '0;
            y_d       = '0;
            first_w_d = '0;
            mism_d    = 1'b0;
            err_d     = 1'b0;
            shadow_d  = cfg_en;
            if ((state_q != WAIT_FRAME) && rx_dv) begin
                state_d = LINE;
                we_d    = 1'b1;
            end else begin
                state_d = BLANK;
            end
        end else begin
            unique case (state_q)
                WAIT_FRAME: ;
                BLANK: begin
                    if (rx_dv) begin
                        state_d = LINE;
                        x_d     = '0;
                        we_d    = 1'b1;
                    end
                end
                LINE: begin
                    if (rx_dv) begin
                        // Past the last address the pixel is dropped and x holds.
                        if (x_cnt == X_MAX) begin
                            err_d = 1'b1;
                        end else begin
                            x_d  = x_cnt + ADDR_W'(1);
                            we_d = 1'b1;
                        end
                    end else begin
                        state_d = BLANK;
                        y_d     = (y_cnt == Y_MAX) ? y_cnt : y_cnt + Y_W'(1);
                        if (y_cnt == '0) begin
                            first_w_d = line_len;
                        end else if (line_len != first_w_q) begin
                            mism_d = 1'b1;
                        end
                    end
                end
                default: state_d = WAIT_FRAME;
            endcase
        end

        // hs looking active while pixels flow means the sync polarity setting is
        // wrong; treat that frame as unstable so it never contributes to lock.
        if (hs_act && rx_dv && (state_d == LINE)) begin
            mism_d = 1'b1;
        end

        win_d    = we_d && (x_d >= X_WIN) && (y_d >= Y_WIN);
        locked_d = (stable_d == LOCK_N);
        use_d    = win_d && locked_d && shadow_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WAIT_FRAME;
            vs_act_q     <= 1'b0;
            first_w_q    <= '0;
            mism_q       <= 1'b0;
            shadow_q     <= 1'b0;
            stable_q     <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            buf_we       <= 1'b0;
            win_valid    <= 1'b0;
            use_median   <= 1'b0;
            locked       <= 1'b0;
            frame_width  <= '0;
            frame_height <= '0;
            err_overflow <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_act_q     <= vs_act;
            first_w_q    <= first_w_d;
            mism_q       <= mism_d;
            shadow_q     <= shadow_d;
            stable_q     <= stable_d;
            x_cnt        <= x_d;
            y_cnt        <= y_d;
            buf_we       <= we_d;
            win_valid    <= win_d;
            use_median   <= use_d;
            locked       <= locked_d;
            frame_width  <= fw_d;
            frame_height <= fh_d;
            err_overflow <= err_d;
        end
    end

endmodule

// File: tb/tb_median_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_median_frame_ctrl
//
// Drives two controllers with the same video stream: a full-size one
// (ADDR_W=11) and a narrow one (ADDR_W=3) that overflows on lines longer than
// 8 pixels. A frame-level model predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_median_frame_ctrl;

    localparam int AW  = 11;
    localparam int AWS = 3;
    localparam int YW  = 11;
    localparam int KER = 5;
    localparam int R   = KER / 2;
    localparam int L   = 2;

    logic clk;
    logic rst;
    logic rx_dv, rx_hs, rx_vs, cfg_en;

    logic [AW-1:0]  buf_addr_b, x_cnt_b;
    logic           buf_we_b, win_valid_b, use_median_b, locked_b, err_overflow_b;
    logic [YW-1:0]  y_cnt_b, frame_height_b;
    logic [AW:0]    frame_width_b;

    logic [AWS-1:0] buf_addr_s, x_cnt_s;
    logic           buf_we_s, win_valid_s, use_median_s, locked_s, err_overflow_s;
    logic [YW-1:0]  y_cnt_s, frame_height_s;
    logic [AWS:0]   frame_width_s;

    median_frame_ctrl #(.ADDR_W(AW), .Y_W(YW), .KERNEL(KER), .LOCK_FRAMES(L),
                        .SYNC_ACT_HIGH(1'b1)) u_big (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
        .cfg_en(cfg_en), .buf_addr(buf_addr_b), .buf_we(buf_we_b),
        .x_cnt(x_cnt_b), .y_cnt(y_cnt_b), .win_valid(win_valid_b),
        .use_median(use_median_b), .locked(locked_b),
        .frame_width(frame_width_b), .frame_height(frame_height_b),
        .err_overflow(err_overflow_b)
    );

    median_frame_ctrl #(.ADDR_W(AWS), .Y_W(YW), .KERNEL(KER), .LOCK_FRAMES(L),
                        .SYNC_ACT_HIGH(1'b1)) u_small (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
        .cfg_en(cfg_en), .buf_addr(buf_addr_s), .buf_we(buf_we_s),
        .x_cnt(x_cnt_s), .y_cnt(y_cnt_s), .win_valid(win_valid_s),
        .use_median(use_median_s), .locked(locked_s),
        .frame_width(frame_width_s), .frame_height(frame_height_s),
        .err_overflow(err_overflow_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Frame-level reference model; index 0 = big, 1 = small.
    int m_cnt[2];
    int m_prev_w[2];
    int m_prev_h[2];
    bit m_err[2];
    bit m_shadow;
    bit m_in_frame;
    bit m_mism;
    int m_y;
    int m_first_len;
    int use_count;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_prev_w[k] = 0; m_prev_h[k] = 0; m_err[k] = 1'b0;
        end
        m_shadow = 1'b0; m_in_frame = 1'b0; m_mism = 1'b0;
        m_y = 0; m_first_len = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every output of both instances with the model for the cycle just
    // clocked. px: the cycle carried a pixel of an open frame with index xi.
    task automatic check_cycle(input bit px, input int xi);
        int cap;
        bit we_e, win_e, lk_e, use_e;
        logic [31:0] o_we, o_x, o_addr, o_y, o_win, o_use, o_lk, o_fw, o_fh, o_err;
        for (int k = 0; k < 2; k++) begin
            cap = (k == 0) ? (1 << AW) : (1 << AWS);
            if (px && xi >= cap) m_err[k] = 1'b1;
            we_e  = px && (xi < cap);
            win_e = we_e && (xi >= 2 * R) && (m_y >= 2 * R);
            lk_e  = (m_cnt[k] == L);
            use_e = win_e && lk_e && m_shadow;
            if (k == 0) begin
                o_we = 32'(buf_we_b); o_x = 32'(x_cnt_b); o_addr = 32'(buf_addr_b);
                o_y = 32'(y_cnt_b); o_win = 32'(win_valid_b); o_use = 32'(use_median_b);
                o_lk = 32'(locked_b); o_fw = 32'(frame_width_b);
                o_fh = 32'(frame_height_b); o_err = 32'(err_overflow_b);
            end else begin
                o_we = 32'(buf_we_s); o_x = 32'(x_cnt_s); o_addr = 32'(buf_addr_s);
                o_y = 32'(y_cnt_s); o_win = 32'(win_valid_s); o_use = 32'(use_median_s);
                o_lk = 32'(locked_s); o_fw = 32'(frame_width_s);
                o_fh = 32'(frame_height_s); o_err = 32'(err_overflow_s);
            end
            chk($sformatf("buf_we[%0d]", k), o_we, 32'(we_e));
            if (px) begin
                chk($sformatf("x_cnt[%0d]", k), o_x, (xi < cap) ? xi : cap - 1);
                chk($sformatf("buf_addr[%0d]", k), o_addr, (xi < cap) ? xi : cap - 1);
            end
            chk($sformatf("y_cnt[%0d]", k), o_y, m_y);
            chk($sformatf("win_valid[%0d]", k), o_win, 32'(win_e));
            chk($sformatf("use_median[%0d]", k), o_use, 32'(use_e));
            chk($sformatf("locked[%0d]", k), o_lk, 32'(lk_e));
            chk($sformatf("frame_width[%0d]", k), o_fw, m_prev_w[k]);
            chk($sformatf("frame_height[%0d]", k), o_fh, m_prev_h[k]);
            chk($sformatf("err_overflow[%0d]", k), o_err, 32'(m_err[k]));
            if (k == 0 && o_use === 32'd1) use_count++;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, 32'(buf_addr_b), 0);
        chk({tag, "_we"}, 32'(buf_we_b), 0);
        chk({tag, "_x"}, 32'(x_cnt_b), 0);
        chk({tag, "_y"}, 32'(y_cnt_b), 0);
        chk({tag, "_win"}, 32'(win_valid_b), 0);
        chk({tag, "_use"}, 32'(use_median_b), 0);
        chk({tag, "_lock"}, 32'(locked_b), 0);
        chk({tag, "_fw"}, 32'(frame_width_b), 0);
        chk({tag, "_fh"}, 32'(frame_height_b), 0);
        chk({tag, "_err"}, 32'(err_overflow_b), 0);
    endtask

    task automatic blank(input int n);
        rx_dv = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check_cycle(1'b0, 0);
        end
    endtask

    // One line of len pixels starting at pixel index start, then gap idle
    // cycles with a one-cycle hs pulse inside the gap.
    task automatic send_line(input int len, input int start, input int gap);
        for (int i = start; i < len; i++) begin
            rx_dv = 1'b1;
            step();
            check_cycle(1'b1, i);
        end
        rx_dv = 1'b0;
        if (m_y == 0) m_first_len = len;
        else if (len != m_first_len) m_mism = 1'b1;
        m_y++;
        for (int g = 0; g < gap; g++) begin
            rx_hs = (g == 1);
            step();
            check_cycle(1'b0, 0);
        end
        rx_hs = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h);
        blank(2);
        for (int y = 0; y < h; y++) send_line(w, 0, 3);
    endtask

    // vs rises for one cycle: the model closes the frame, then opens the next.
    task automatic frame_boundary(input bit with_px);
        int w, cap;
        bit good;
        if (m_in_frame) begin
            for (int k = 0; k < 2; k++) begin
                cap  = (k == 0) ? (1 << AW) : (1 << AWS);
                w    = (m_first_len < cap) ? m_first_len : cap;
                good = (w != 0) && (m_y != 0) && (w == m_prev_w[k]) &&
                       (m_y == m_prev_h[k]) && !m_mism && !m_err[k];
                m_cnt[k]    = good ? ((m_cnt[k] < L) ? m_cnt[k] + 1 : L) : 0;
                m_prev_w[k] = w;
                m_prev_h[k] = m_y;
            end
        end
        m_shadow = cfg_en; m_in_frame = 1'b1; m_y = 0; m_first_len = 0;
        m_mism = 1'b0; m_err[0] = 1'b0; m_err[1] = 1'b0;
        rx_vs = 1'b1;
        rx_dv = with_px;
        step();
        check_cycle(with_px, 0);
        rx_vs = 1'b0;
    endtask

    initial begin
        int w, h, len;
        model_reset();
        rx_dv = 1'b0; rx_hs = 1'b0; rx_vs = 1'b0; cfg_en = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) step();
        check_zero("por");
        rst = 1'b1;
        step();
        check_cycle(1'b0, 0);

        // Reset in the middle of a line (x=5, dv high).
        frame_boundary(1'b0);
        blank(2);
        for (int i = 0; i < 6; i++) begin
            rx_dv = 1'b1;
            step();
            check_cycle(1'b1, i);
        end
        #2 rst = 1'b0;
        #1 check_zero("rst_async");
        step();
        check_zero("rst_next");
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            check_cycle(1'b0, 0);
            chk("wait_x", 32'(x_cnt_b), 0);
        end

        // Stable 8x6 stream with median enabled.
        cfg_en = 1'b1;
        blank(2);
        frame_boundary(1'b0);
        send_frame(8, 6); frame_boundary(1'b0);
        chk("f1_width", 32'(frame_width_b), 8);
        chk("f1_height", 32'(frame_height_b), 6);
        chk("f1_locked", 32'(locked_b), 0);
        send_frame(8, 6); frame_boundary(1'b0);
        chk("f2_locked", 32'(locked_b), 0);
        send_frame(8, 6); frame_boundary(1'b0);
        chk("f3_locked", 32'(locked_b), 1);
        use_count = 0;
        send_frame(8, 6);
        chk("f4_use_count", use_count, 8);
        frame_boundary(1'b0);

        // One 9-pixel line drops lock; two clean frames relock.
        blank(2);
        send_line(8, 0, 3); send_line(9, 0, 3);
        repeat (4) send_line(8, 0, 3);
        frame_boundary(1'b0);
        chk("wide_unlock", 32'(locked_b), 0);
        send_frame(8, 6); frame_boundary(1'b0);
        chk("relock1", 32'(locked_b), 0);
        send_frame(8, 6); frame_boundary(1'b0);
        chk("relock2", 32'(locked_b), 1);

        // cfg_en dropped mid-frame only takes effect at the next frame.
        use_count = 0;
        blank(2);
        repeat (3) send_line(8, 0, 3);
        cfg_en = 1'b0;
        repeat (3) send_line(8, 0, 3);
        chk("cfg_drop_use", use_count, 8);
        frame_boundary(1'b0);
        use_count = 0;
        send_frame(8, 6);
        chk("cfg_off_use", use_count, 0);
        cfg_en = 1'b1;
        frame_boundary(1'b0);

        // 10-pixel line overflows the narrow instance.
        blank(2);
        send_line(8, 0, 3); send_line(10, 0, 3);
        chk("ovf_small", 32'(err_overflow_s), 1);
        chk("ovf_big", 32'(err_overflow_b), 0);
        repeat (4) send_line(8, 0, 3);
        frame_boundary(1'b0);
        chk("ovf_clear", 32'(err_overflow_s), 0);
        chk("ovf_locked", 32'(locked_s), 0);

        // vs edge together with the first pixel of a line.
        send_frame(8, 6);
        frame_boundary(1'b1);
        chk("coinc_x", 32'(x_cnt_b), 0);
        chk("coinc_y", 32'(y_cnt_b), 0);
        chk("coinc_we", 32'(buf_we_b), 1);
        chk("coinc_height", 32'(frame_height_b), 6);
        send_line(8, 1, 3);
        repeat (5) send_line(8, 0, 3);
        frame_boundary(1'b0);

        // Randomized geometry, occasional long lines and random enables.
        w = 8; h = 6;
        for (int f = 0; f < 12; f++) begin
            if (f % 3 == 0) begin
                w = $urandom_range(5, 10);
                h = $urandom_range(5, 7);
            end
            cfg_en = 1'($urandom_range(0, 1));
            blank($urandom_range(1, 3));
            for (int y = 0; y < h; y++) begin
                len = ($urandom_range(0, 9) == 0) ? w + 1 : w;
                send_line(len, 0, $urandom_range(2, 4));
            end
            frame_boundary(1'b0);
        end
        blank(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
